// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_pkg
// Description : Shared defaults and helper functions for the multiplier
//               arbiter: default operand width and requester count, id-width
//               derivation, and the modulo-R round-robin pointer wrap.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arbiter_pkg;

   localparam int DEF_N = 16;
   localparam int DEF_R = 4;

   // Width of a requester index; at least one bit even for degenerate R.
   function automatic int id_width(input int r);
      return (r <= 1) ? 1 : $clog2(r);
   endfunction

   // Successor of requester i, wrapped explicitly so non-power-of-2 R works.
   function automatic int next_ptr(input int i, input int r);
      return (i + 1 >= r) ? 0 : i + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter over R requesters. Search starts at the
//               pointer and wraps; the winner's successor becomes the new
//               pointer. Grants are suppressed while rst is high.
// Revision    : 1.0 - initial release
// ============================================================================
import mult_arbiter_pkg::*;

module rr_arbiter #(
   parameter int R   = DEF_R,
   parameter int IDW = id_width(R)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [R-1:0]   req,
   input  logic           advance,
   output logic [R-1:0]   grant,
   output logic           grant_any,
   output logic [IDW-1:0] grant_id
);

   logic [IDW-1:0] r_ptr;
   logic [R-1:0]   w_grant;
   logic           w_any;
   logic [IDW-1:0] w_id;
   logic [IDW:0]   w_idx;
   logic [IDW-1:0] w_sel;

   // Scan ptr, ptr+1, ... (mod R) and grant the first asserted request.
   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      w_id    = '0;
      w_idx   = '0;
      w_sel   = '0;
      for (int k = 0; k < R; k++) begin
         w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
         if (w_idx >= (IDW+1)'(R)) begin
            w_idx = w_idx - (IDW+1)'(R);
         end
         w_sel = w_idx[IDW-1:0];
         if (!w_any && req[w_sel]) begin
            w_grant[w_sel] = 1'b1;
            w_any          = 1'b1;
            w_id           = w_sel;
         end
      end
      if (rst || !advance) begin
         w_grant = '0;
         w_any   = 1'b0;
         w_id    = '0;
      end
   end

   // Pointer moves past the winner; it stays put on idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= IDW'(next_ptr(int'(w_id), R));
      end
   end

   assign grant     = w_grant;
   assign grant_any = w_any;
   assign grant_id  = w_id;

endmodule
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module      : multiplier
// Description : Combinational unsigned N x N -> 2N multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier #(
   parameter int N = 16
) (
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic [2*N-1:0] o_p
);

   // Both operands are widened first so the full 2N-bit product is kept.
   assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Shares one combinational multiplier among R requesters.
//               A round-robin grant registers the winning operands (issue
//               stage); the product is registered with the winner's id
//               (result stage), giving a fixed two-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
import mult_arbiter_pkg::*;

module mult_arbiter #(
   parameter int N = DEF_N,
   parameter int R = DEF_R
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [R-1:0]              req_valid,
   input  logic [R*N-1:0]            req_a,
   input  logic [R*N-1:0]            req_b,
   output logic [R-1:0]              req_ready,
   output logic                      rsp_valid,
   output logic [id_width(R)-1:0]    rsp_id,
   output logic [2*N-1:0]            rsp_p,
   output logic                      busy
);

   localparam int IDW = id_width(R);

   logic [R-1:0]   w_grant;
   logic           w_any;
   logic [IDW-1:0] w_id;
   logic [N-1:0]   w_a;
   logic [N-1:0]   w_b;
   logic [2*N-1:0] w_prod;

   logic [N-1:0]   r_op_a;
   logic [N-1:0]   r_op_b;
   logic           r_s1_valid;
   logic [IDW-1:0] r_s1_id;
   logic           r_rsp_valid;
   logic [IDW-1:0] r_rsp_id;
   logic [2*N-1:0] r_rsp_p;

   // No backpressure downstream, so the arbiter may grant every cycle.
   rr_arbiter #(
      .R   (R),
      .IDW (IDW)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .advance   (1'b1),
      .grant     (w_grant),
      .grant_any (w_any),
      .grant_id  (w_id)
   );

   // Select the granted requester's operand pair (grant is one-hot).
   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int k = 0; k < R; k++) begin
         if (w_grant[k]) begin
            w_a = req_a[k*N +: N];
            w_b = req_b[k*N +: N];
         end
      end
   end

   // Issue stage: capture operands and owner; operands hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_s1_valid <= 1'b0;
         r_s1_id    <= '0;
      end else begin
         r_s1_valid <= w_any;
         if (w_any) begin
            r_op_a  <= w_a;
            r_op_b  <= w_b;
            r_s1_id <= w_id;
         end
      end
   end

   multiplier #(
      .N (N)
   ) u_mul (
      .i_a (r_op_a),
      .i_b (r_op_b),
      .o_p (w_prod)
   );

   // Result stage: register product and id; both hold on bubble cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_p     <= '0;
      end else begin
         r_rsp_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_rsp_p  <= w_prod;
            r_rsp_id <= r_s1_id;
         end
      end
   end

   assign req_ready = w_grant;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_p     = r_rsp_p;
   assign busy      = r_s1_valid | r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter: per-cycle vector table
//               on an R=4 instance plus a wrap sequence on an R=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  rdy;
      logic        rv;
      logic [1:0]  id;
      logic [31:0] p;
      logic        bsy;
   } vec_t;

   localparam int NV = 29;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_p;
   logic        busy;

   logic [2:0]  v3;
   logic [47:0] a3;
   logic [47:0] b3;
   logic [2:0]  rdy3;
   logic        rv3;
   logic [1:0]  id3;
   logic [31:0] p3;
   logic        bsy3;

   int n_pass;
   int n_tot;
   vec_t tbl [NV];

   mult_arbiter #(.N(16), .R(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .busy      (busy)
   );

   mult_arbiter #(.N(16), .R(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (v3),
      .req_a     (a3),
      .req_b     (b3),
      .req_ready (rdy3),
      .rsp_valid (rv3),
      .rsp_id    (id3),
      .rsp_p     (p3),
      .busy      (bsy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [63:0] a,
                               input logic [63:0] b, input logic [3:0] rdy, input logic rv,
                               input logic [1:0] id, input logic [31:0] p, input logic bsy);
      vec_t t;
      t.rst = r; t.v = v; t.a = a; t.b = b; t.rdy = rdy;
      t.rv = rv; t.id = id; t.p = p; t.bsy = bsy;
      return t;
   endfunction

   // Drive R=3 inputs for one cycle, then check that instance's outputs.
   task automatic step3(input int s, input logic [2:0] v, input logic [2:0] erdy,
                        input logic erv, input logic [1:0] eid, input logic [31:0] ep);
      v3 = v;
      @(negedge clk);
      chk($sformatf("r3_ready_s%0d", s), 64'(rdy3), 64'(erdy));
      chk($sformatf("r3_rsp_valid_s%0d", s), 64'(rv3), 64'(erv));
      chk($sformatf("r3_rsp_id_s%0d", s), 64'(id3), 64'(eid));
      chk($sformatf("r3_rsp_p_s%0d", s), 64'(p3), 64'(ep));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] z;
      logic [63:0] ab;
      logic [63:0] bb;
      logic [63:0] af;
      logic [63:0] bf;
      logic [63:0] aw;
      logic [63:0] bw;
      logic [63:0] bz;
      n_pass = 0;
      n_tot  = 0;
      z  = 64'd0;
      ab = {16'd0, 16'd0, 16'd11, 16'd7};
      bb = {16'd0, 16'd0, 16'd13, 16'd9};
      af = {16'd4, 16'd3, 16'd2, 16'd1};
      bf = {16'd10, 16'd10, 16'd10, 16'd10};
      aw = {16'd0, 16'hFFFF, 16'd0, 16'd0};
      bw = {16'd0, 16'hFFFF, 16'd0, 16'd0};
      bz = {16'hFFFF, 16'd0, 16'd0, 16'd0};

      //            rst   valid    a   b   ready  rv  id  p              busy
      tbl[0]  = mk(1'b1, 4'b0100, {16'd0,16'd3,16'd0,16'd0}, {16'd0,16'd5,16'd0,16'd0},
                   4'b0000, 1'b0, 2'd0, 32'd0, 1'b0);
      tbl[1]  = mk(1'b0, 4'b0100, {16'd0,16'd3,16'd0,16'd0}, {16'd0,16'd5,16'd0,16'd0},
                   4'b0100, 1'b0, 2'd0, 32'd0, 1'b0);
      tbl[2]  = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd0, 32'd0,   1'b1);
      tbl[3]  = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b1, 2'd2, 32'd15,  1'b1);
      tbl[4]  = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd2, 32'd15,  1'b0);
      tbl[5]  = mk(1'b0, 4'b0011, ab, bb, 4'b0001, 1'b0, 2'd2, 32'd15,  1'b0);
      tbl[6]  = mk(1'b0, 4'b0010, ab, bb, 4'b0010, 1'b0, 2'd2, 32'd15,  1'b1);
      tbl[7]  = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b1, 2'd0, 32'd63,  1'b1);
      tbl[8]  = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b1, 2'd1, 32'd143, 1'b1);
      tbl[9]  = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd1, 32'd143, 1'b0);
      tbl[10] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd1, 32'd143, 1'b0);
      tbl[11] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd1, 32'd143, 1'b0);
      tbl[12] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd1, 32'd143, 1'b0);
      tbl[13] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd1, 32'd143, 1'b0);
      tbl[14] = mk(1'b0, 4'b0100, aw, bw, 4'b0100, 1'b0, 2'd1, 32'd143, 1'b0);
      tbl[15] = mk(1'b0, 4'b1000, z,  bz, 4'b1000, 1'b0, 2'd1, 32'd143, 1'b1);
      tbl[16] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b1, 2'd2, 32'hFFFE0001, 1'b1);
      tbl[17] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b1, 2'd3, 32'd0,   1'b1);
      tbl[18] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd3, 32'd0,   1'b0);
      tbl[19] = mk(1'b0, 4'b1111, af, bf, 4'b0001, 1'b0, 2'd3, 32'd0,   1'b0);
      tbl[20] = mk(1'b0, 4'b1111, af, bf, 4'b0010, 1'b0, 2'd3, 32'd0,   1'b1);
      tbl[21] = mk(1'b0, 4'b1111, af, bf, 4'b0100, 1'b1, 2'd0, 32'd10,  1'b1);
      tbl[22] = mk(1'b0, 4'b1111, af, bf, 4'b1000, 1'b1, 2'd1, 32'd20,  1'b1);
      tbl[23] = mk(1'b0, 4'b1111, af, bf, 4'b0001, 1'b1, 2'd2, 32'd30,  1'b1);
      tbl[24] = mk(1'b1, 4'b1111, af, bf, 4'b0000, 1'b1, 2'd3, 32'd40,  1'b1);
      tbl[25] = mk(1'b0, 4'b1111, af, bf, 4'b0001, 1'b0, 2'd0, 32'd0,   1'b0);
      tbl[26] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd0, 32'd0,   1'b1);
      tbl[27] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b1, 2'd0, 32'd10,  1'b1);
      tbl[28] = mk(1'b0, 4'b0000, z,  z,  4'b0000, 1'b0, 2'd0, 32'd10,  1'b0);

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      v3        = '0;
      a3        = '0;
      b3        = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         rst       = tbl[i].rst;
         req_valid = tbl[i].v;
         req_a     = tbl[i].a;
         req_b     = tbl[i].b;
         @(negedge clk);
         chk($sformatf("ready_r%0d", i),     64'(req_ready), 64'(tbl[i].rdy));
         chk($sformatf("rsp_valid_r%0d", i), 64'(rsp_valid), 64'(tbl[i].rv));
         chk($sformatf("rsp_id_r%0d", i),    64'(rsp_id),    64'(tbl[i].id));
         chk($sformatf("rsp_p_r%0d", i),     64'(rsp_p),     64'(tbl[i].p));
         chk($sformatf("busy_r%0d", i),      64'(busy),      64'(tbl[i].bsy));
         @(posedge clk);
         #1;
      end

      // R=3 instance: pointer 0 -> grant 2 wraps to 0, then 0, 2, 0.
      rst       = 1'b0;
      req_valid = '0;
      a3        = {16'd5, 16'd0, 16'd7};
      b3        = {16'd6, 16'd0, 16'd8};
      step3(0, 3'b100, 3'b100, 1'b0, 2'd0, 32'd0);
      step3(1, 3'b101, 3'b001, 1'b0, 2'd0, 32'd0);
      step3(2, 3'b101, 3'b100, 1'b1, 2'd2, 32'd30);
      step3(3, 3'b101, 3'b001, 1'b1, 2'd0, 32'd56);
      step3(4, 3'b000, 3'b000, 1'b1, 2'd2, 32'd30);
      step3(5, 3'b000, 3'b000, 1'b1, 2'd0, 32'd56);
      step3(6, 3'b000, 3'b000, 1'b0, 2'd0, 32'd56);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one instance of the team's combinational `multiplier` (N-bit x N-bit -> 2N-bit, unsigned) among R requesters, e.g. the butterfly lanes of the NTT core.
- A round-robin arbiter accepts at most one operand pair per cycle and registers it into the multiplier.
- The product is registered and returned, tagged with the requester id, at a fixed latency.

Parameters:
N, 16, operand width in bits; product width is 2N.
R, 4, number of requesters (R >= 2).
IDW, $clog2(R), requester id width (derived, not overridden).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  R  bit i = requester i presents an operand pair.
req_a  input  R*N  operand a of requester i in bits [i*N +: N].
req_b  input  R*N  operand b of requester i in bits [i*N +: N].
req_ready  output  R  one-hot or zero; bit i = requester i's pair accepted this cycle.
rsp_valid  output  1  product valid this cycle (single-cycle pulse, no backpressure).
rsp_id  output  IDW  requester index owning rsp_p.
rsp_p  output  2N  product a*b.
busy  output  1  a request is in the issue or result stage.

Behaviour:
- Handshake
  - Transfer for requester i in cycle t when req_valid[i] && req_ready[i].
  - A requester holds valid and operands stable until it sees ready.
  - req_ready is combinational from req_valid and the pointer.
  - req_ready is 0 whenever rst is 1.
- Arbitration
  - Round-robin pointer ptr (IDW bits), reset 0.
  - Search order: ptr, ptr+1, ..., wrapping mod R. The first asserted req_valid wins.
  - On a grant to i: ptr <= (i+1) mod R, with explicit wrap when R is not a power of 2.
  - No valid: no grant and ptr is unchanged.
  - Throughput: 1 grant per cycle. No idle cycle is required between grants.
  - Grant never depends on pipeline state, because there is no backpressure.
- Pipeline (fixed latency 2)
  - Stage 1 (issue), edge after t: op_a, op_b <= granted req_a/req_b; s1_valid <= grant_any; s1_id <= i. If no grant, op_a/op_b hold their previous values.
  - Multiplier inputs are driven by op_a/op_b.
  - Stage 2 (result), edge after t+1: rsp_p <= multiplier output; rsp_valid <= s1_valid; rsp_id <= s1_id.
  - rsp_valid is high exactly in cycle t+2 for a transfer in cycle t.
  - On cycles with rsp_valid=0, rsp_p and rsp_id hold their last value.
- busy = s1_valid | rsp_valid.
- Arithmetic
  - Full unsigned product, 2N bits, no truncation and no modular reduction.
  - Max case: (2^N-1)^2 fits in 2N bits.
- Reset
  - Values: rsp_valid=0, rsp_id=0, rsp_p=0, s1_valid=0, s1_id=0, op_a=op_b=0, ptr=0, busy=0.
  - Reset mid-operation discards in-flight stage-1/stage-2 entries. No rsp_valid pulse is produced for them, including in the cycle after rst falls.
  - A request present in the same cycle as rst is not accepted (req_ready=0).
- Simultaneous events
  - A new grant, a stage-1 advance and a stage-2 output all occur in the same cycle without conflict. Back-to-back responses for different ids come on consecutive cycles.

Decomposition:
- Package mult_arbiter_pkg holds:
  - the default N and R;
  - a helper function for the id width;
  - a function next_ptr(i, R) for the modulo-R wrap.
- Natural sub-module: rr_arbiter #(R).
  - Inputs: clk, rst, req (R), and advance.
  - Outputs: grant (one-hot R), grant_any, grant_id (IDW).
  - Contains the ptr register.
  - The top adds the operand mux, the two pipeline stages and the `multiplier` #(N) instance.

Test Plan:
- Single request: reset, then req_valid=4'b0100 with a2=3, b2=5 at t. Expected: req_ready=4'b0100 at t; rsp_valid=1, rsp_id=2, rsp_p=15 at t+2 only; busy high at t+1 and t+2.
- Fairness: all four valid continuously with a_i=i+1, b_i=10, ptr=0. Expected: grants 0,1,2,3,0,... one per cycle; rsp_p sequence 10,20,30,40,10 with ids 0,1,2,3,0, starting 2 cycles after the first grant.
- Pointer skip/wrap: ptr=3, valid=4'b0011. Expected: grant to 0 (wrap), then ptr=1 and grant to 1. With R=3, verify the wrap 2 -> 0.
- Width corner: N=16, a=b=16'hFFFF. Expected: rsp_p=32'hFFFE0001. Also a=0, b=16'hFFFF gives 0.
- Reset mid-flight: grants at t and t+1, rst=1 at t+1. Expected: no rsp_valid at t+2 or t+3; busy=0 after the reset edge; ptr back to 0; next grant order starts at requester 0.
- Idle/hold: no requests for 5 cycles after a response. Expected: req_ready=0, rsp_valid=0, rsp_p/rsp_id hold the last values, ptr unchanged.
